// File: rtl/univ_shift_seq.sv
// Universal shift register sequencer: parallel load plus multi-bit shift operations
// (logical/serial, circular, arithmetic, through-carry) executed one bit per enabled cycle.
module univ_shift_seq #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] pdata,
    input  logic             start,
    input  logic [CNTW-1:0]  count,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             d,
    input  logic             carry_in,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [CNTW-1:0] CNT_ONE = 1;

    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;

    logic             shifted_out;
    logic             shift_in;

    // Bit leaving the register this shift, and the bit entering at the other end.
    always_comb begin
        shifted_out = dir_q ? out_q[WIDTH-1] : out_q[0];
        shift_in    = d;
        case (mode_q)
            2'b00:   shift_in = d;
            2'b01:   shift_in = shifted_out;
            2'b10:   shift_in = dir_q ? 1'b0 : out_q[WIDTH-1];
            default: shift_in = carry_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        out_d   = out_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    out_d = pdata;
                end else if (start) begin
                    if (count != '0) begin
                        cnt_d   = count;
                        dir_d   = dir;
                        mode_d  = mode;
                        state_d = SHIFT;
                        if (mode == 2'b11) begin
                            carry_d = carry_in;
                        end
                    end else begin
                        // Zero-length operation completes immediately without touching data.
                        done_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (en) begin
                    if (dir_q) begin
                        out_d = {out_q[WIDTH-2:0], shift_in};
                    end else begin
                        out_d = {shift_in, out_q[WIDTH-1:1]};
                    end
                    carry_d = shifted_out;
                    cnt_d   = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 2'b00;
            out_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            done_q  <= done_d;
        end
    end

    assign out       = out_q;
    assign carry_out = carry_q;
    assign busy      = (state_q == SHIFT);
    assign done      = done_q;

endmodule

// File: tb/tb_univ_shift_seq.sv
// Self-checking bench for univ_shift_seq: directed vector table, hand-written stall/reset
// sequences and randomized operations compared against an arithmetic reference model.
module tb_univ_shift_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         en = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] pdata = '0;
    logic         start = 1'b0;
    logic [3:0]   count = '0;
    logic         dir = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         d = 1'b0;
    logic         carry_in = 1'b0;
    logic [W-1:0] out_w;
    logic         carry_w;
    logic         busy_w;
    logic         done_w;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_out = 0;
    int m_c   = 0;

    univ_shift_seq #(.WIDTH(W), .CNTW(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .load      (load),
        .pdata     (pdata),
        .start     (start),
        .count     (count),
        .dir       (dir),
        .mode      (mode),
        .d         (d),
        .carry_in  (carry_in),
        .out       (out_w),
        .carry_out (carry_w),
        .busy      (busy_w),
        .done      (done_w)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pd;
        int         cnt;
        bit         dr;
        logic [1:0] md;
        bit         ci;
        bit         dv;
        logic [7:0] exp_out;
        bit         exp_c;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One 1-bit shift computed with integer arithmetic.
    task automatic model_shift(input bit din, input bit dr, input logic [1:0] md);
        int leaving;
        int inb;
        leaving = dr ? ((m_out >> (W-1)) & 1) : (m_out & 1);
        case (md)
            2'b00:   inb = din;
            2'b01:   inb = leaving;
            2'b10:   inb = dr ? 0 : ((m_out >> (W-1)) & 1);
            default: inb = m_c;
        endcase
        if (dr) m_out = ((m_out * 2) + inb) % (1 << W);
        else    m_out = (m_out / 2) + inb * (1 << (W-1));
        m_c = leaving;
    endtask

    task automatic run_op(input logic [7:0] pd, input int cnt, input bit dr, input logic [1:0] md,
                          input bit ci, input bit dv, input bit rnd_d, input bit stall,
                          input bit garbage, input bit do_load);
        int rem;
        int cyc;
        bit e;
        bit dd;
        if (do_load) begin
            load = 1'b1;
            pdata = pd;
            tick();
            load = 1'b0;
            m_out = pd;
            chk("load_out", out_w, m_out);
            chk("load_done_clear", done_w, 0);
        end
        start = 1'b1;
        count = cnt[3:0];
        dir = dr;
        mode = md;
        carry_in = ci;
        en = 1'b1;
        d = rnd_d ? 1'($urandom % 2) : dv;
        tick();
        start = 1'b0;
        count = 4'($urandom);
        dir = 1'($urandom);
        mode = 2'($urandom);
        carry_in = 1'($urandom);
        if (cnt == 0) begin
            chk("zero_done", done_w, 1);
            chk("zero_busy", busy_w, 0);
            chk("zero_out", out_w, m_out);
            chk("zero_carry", carry_w, m_c);
        end else begin
            if (md == 2'b11) m_c = ci;
            chk("start_busy", busy_w, 1);
            rem = cnt;
            cyc = 0;
            while (rem > 0 && cyc < 200) begin
                e  = stall ? ($urandom % 3 != 0) : 1'b1;
                dd = rnd_d ? 1'($urandom % 2) : dv;
                en = e;
                d = dd;
                if (garbage) begin
                    load  = 1'($urandom);
                    start = 1'($urandom);
                    pdata = 8'($urandom);
                end
                if (e) begin
                    model_shift(dd, dr, md);
                    rem--;
                end
                tick();
                cyc++;
                if (rem > 0) begin
                    chk("mid_busy", busy_w, 1);
                    chk("mid_done", done_w, 0);
                end else begin
                    chk("end_busy", busy_w, 0);
                    chk("end_done", done_w, 1);
                    chk("end_out", out_w, m_out);
                    chk("end_carry", carry_w, m_c);
                end
            end
            chk("op_timeout", rem, 0);
        end
        load = 1'b0;
        start = 1'b0;
        en = 1'b1;
    endtask

    vec_t vecs[4];
    int   busy_cycles;

    initial begin
        vecs[0] = '{pd: 8'hA5, cnt: 3, dr: 1'b0, md: 2'b00, ci: 1'b0, dv: 1'b1, exp_out: 8'hF4, exp_c: 1'b1};
        vecs[1] = '{pd: 8'hA5, cnt: 4, dr: 1'b1, md: 2'b01, ci: 1'b0, dv: 1'b0, exp_out: 8'h5A, exp_c: 1'b0};
        vecs[2] = '{pd: 8'h84, cnt: 2, dr: 1'b0, md: 2'b10, ci: 1'b0, dv: 1'b0, exp_out: 8'hE1, exp_c: 1'b0};
        vecs[3] = '{pd: 8'h01, cnt: 1, dr: 1'b0, md: 2'b11, ci: 1'b1, dv: 1'b0, exp_out: 8'h80, exp_c: 1'b1};

        #2;
        chk("rst_out", out_w, 0);
        chk("rst_carry", carry_w, 0);
        chk("rst_busy", busy_w, 0);
        chk("rst_done", done_w, 0);
        tick();
        rstn = 1'b1;

        // Directed vectors
        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i].pd, vecs[i].cnt, vecs[i].dr, vecs[i].md, vecs[i].ci, vecs[i].dv,
                   1'b0, 1'b0, 1'b0, 1'b1);
            chk($sformatf("vec%0d_out", i), out_w, vecs[i].exp_out);
            chk($sformatf("vec%0d_carry", i), carry_w, vecs[i].exp_c);
        end

        // Stalled count=2 run with ignored load/start while busy
        load = 1'b1; pdata = 8'hA5; tick(); load = 1'b0;
        start = 1'b1; count = 4'd2; dir = 1'b0; mode = 2'b00; d = 1'b1; tick(); start = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < 5; c++) begin
            if (busy_w) busy_cycles++;
            en = (c == 0 || c == 4);
            load = (c == 1); start = (c == 2); pdata = 8'h00; count = 4'd7;
            tick();
        end
        load = 1'b0; start = 1'b0; en = 1'b1;
        chk("stall_busy_cycles", busy_cycles, 5);
        chk("stall_out", out_w, 8'hE9);
        chk("stall_carry", carry_w, 0);
        chk("stall_done", done_w, 1);
        m_out = 8'hE9; m_c = 0;

        // Start in the same cycle as done, count above WIDTH
        run_op(8'h00, 12, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(8'h00, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("zero_done_clears", done_w, 0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            run_op(8'($urandom), 1 + int'($urandom % 15), 1'($urandom), 2'($urandom), 1'($urandom),
                   1'b0, 1'b1, 1'b1, 1'b1, 1'($urandom));
        end

        // Asynchronous reset mid-operation
        load = 1'b1; pdata = 8'h3C; tick(); load = 1'b0;
        start = 1'b1; count = 4'd10; dir = 1'b1; mode = 2'b11; carry_in = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_out", out_w, 0);
        chk("arst_carry", carry_w, 0);
        chk("arst_busy", busy_w, 0);
        chk("arst_done", done_w, 0);
        tick(); tick();
        rstn = 1'b1;
        chk("post_rst_done", done_w, 0);
        start = 1'b1; count = 4'd0; mode = 2'b00; tick(); start = 1'b0;
        chk("post_rst_zero_done", done_w, 1);
        chk("post_rst_out", out_w, 0);
        chk("post_rst_busy", busy_w, 0);
        tick();
        chk("post_rst_done_clear", done_w, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
